// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - Iterative AES-128 encryption core, one round per clock, on-the-fly key expansion
// Optional feature macro: AES_ENC_LD_QUEUE_EN (one-deep ld queue plus sticky ovf flag)

// aes_sbox: forward S-box computed as GF(2^8) inverse (x^254) followed by the affine transform
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] d
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ s;
         s = {s[6:0], 1'b0} ^ (8'h1b & {8{s[7]}});
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

   // Inverse via an addition chain to x^254 (0 maps to 0), then affine map with constant 0x63
   always_comb begin
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x7   = gf_mul(x6, a);
      x14  = gf_mul(x7, x7);
      x15  = gf_mul(x14, a);
      x30  = gf_mul(x15, x15);
      x31  = gf_mul(x30, a);
      x62  = gf_mul(x31, x31);
      x63  = gf_mul(x62, a);
      x126 = gf_mul(x63, x63);
      x127 = gf_mul(x126, a);
      inv  = gf_mul(x127, x127);
      d    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

// aes_key_expand_128: holds the current round key and steps to the next one every clock
module aes_key_expand_128 (
   input  logic         clk,
   input  logic         rst,
   input  logic         kld,
   input  logic [127:0] key,
   output logic [31:0]  wo_0,
   output logic [31:0]  wo_1,
   output logic [31:0]  wo_2,
   output logic [31:0]  wo_3
);
   logic [31:0] w0_q, w1_q, w2_q, w3_q, w0_d, w1_d, w2_d, w3_d;
   logic [7:0]  rcon_q, rcon_d;
   logic [7:0]  sw [4];
   logic [31:0] tmp;

   for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (.a(w3_q[8*gi +: 8]), .d(sw[gi]));
   end

   // Next round key: RotWord/SubWord/Rcon on the last word, then the xor chain across the words
   always_comb begin
      tmp = {sw[2], sw[1], sw[0], sw[3]} ^ {rcon_q, 24'h000000};
      if (kld) begin
         w0_d   = key[127:96];
         w1_d   = key[95:64];
         w2_d   = key[63:32];
         w3_d   = key[31:0];
         rcon_d = 8'h01;
      end else begin
         w0_d   = w0_q ^ tmp;
         w1_d   = w1_q ^ w0_q ^ tmp;
         w2_d   = w2_q ^ w1_q ^ w0_q ^ tmp;
         w3_d   = w3_q ^ w2_q ^ w1_q ^ w0_q ^ tmp;
         rcon_d = {rcon_q[6:0], 1'b0} ^ (8'h1b & {8{rcon_q[7]}});
      end
   end

   // Round key registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w0_q   <= '0;
         w1_q   <= '0;
         w2_q   <= '0;
         w3_q   <= '0;
         rcon_q <= 8'h01;
      end else begin
         w0_q   <= w0_d;
         w1_q   <= w1_d;
         w2_q   <= w2_d;
         w3_q   <= w3_d;
         rcon_q <= rcon_d;
      end
   end

   assign wo_0 = w0_q;
   assign wo_1 = w1_q;
   assign wo_2 = w2_q;
   assign wo_3 = w3_q;
endmodule

// aes_enc_iter: top level, ld/done handshake shared with the decrypt core
module aes_enc_iter #(
   parameter int OUT_CLR = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [127:0] key,
   input  logic [127:0] text_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] text_out
`ifdef AES_ENC_LD_QUEUE_EN
   ,
   output logic         ovf
`endif
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_INIT = 2'd1, S_RND = 2'd2} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] state_q, state_d;
   logic [127:0] text_q, text_d;
   logic [127:0] out_q, out_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic         start;
   logic [127:0] start_key, start_text;
   logic [31:0]  wo_0, wo_1, wo_2, wo_3;
   logic [127:0] rk;
   logic [7:0]   sb_out [16];
   logic [7:0]   sr [16];
   logic [7:0]   a0, a1, a2, a3;
   logic [31:0]  col;
   logic [127:0] round_out;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

`ifdef AES_ENC_LD_QUEUE_EN
   logic         qv_q, qv_d;
   logic [127:0] qk_q, qk_d, qt_q, qt_d;
   logic         ovf_q, ovf_d;

   // Launch arbitration: ld while busy parks in the slot; a parked block launches once the done cycle has passed
   always_comb begin
      start      = 1'b0;
      start_key  = key;
      start_text = text_in;
      qv_d       = qv_q;
      qk_d       = qk_q;
      qt_d       = qt_q;
      ovf_d      = ovf_q;
      if (busy_q) begin
         if (ld) begin
            if (!qv_q) begin
               qv_d = 1'b1;
               qk_d = key;
               qt_d = text_in;
            end else begin
               ovf_d = 1'b1;
            end
         end
      end else if (qv_q) begin
         if (ld) begin
            start      = 1'b1;
            start_key  = qk_q;
            start_text = qt_q;
            qk_d       = key;
            qt_d       = text_in;
         end else if (!done_q) begin
            start      = 1'b1;
            start_key  = qk_q;
            start_text = qt_q;
            qv_d       = 1'b0;
         end
      end else if (ld) begin
         start = 1'b1;
      end
   end

   // Queue slot and overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qv_q  <= 1'b0;
         qk_q  <= '0;
         qt_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         qv_q  <= qv_d;
         qk_q  <= qk_d;
         qt_q  <= qt_d;
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign start      = ld;
   assign start_key  = key;
   assign start_text = text_in;
`endif

   aes_key_expand_128 u_key (
      .clk  (clk),
      .rst  (rst),
      .kld  (start),
      .key  (start_key),
      .wo_0 (wo_0),
      .wo_1 (wo_1),
      .wo_2 (wo_2),
      .wo_3 (wo_3)
   );
   assign rk = {wo_0, wo_1, wo_2, wo_3};

   for (genvar gi = 0; gi < 16; gi++) begin : g_sub
      aes_sbox u_sbox (.a(state_q[127-8*gi -: 8]), .d(sb_out[gi]));
   end

   // One cipher round: ShiftRows on the substituted bytes, MixColumns except in round 10, AddRoundKey
   always_comb begin
      round_out = '0;
      a0 = 8'h00;
      a1 = 8'h00;
      a2 = 8'h00;
      a3 = 8'h00;
      col = '0;
      for (int i = 0; i < 16; i++) sr[i] = 8'h00;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[4*c+r] = sb_out[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         if (rnd_q == 4'd10)
            col = {a0, a1, a2, a3};
         else
            col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
         round_out[127-32*c -: 32] = col ^ rk[127-32*c -: 32];
      end
   end

   // Sequencer: a launch always wins (restart), otherwise initial AddRoundKey then rounds 1..10
   always_comb begin
      fsm_d   = fsm_q;
      rnd_d   = rnd_q;
      state_d = state_q;
      text_d  = text_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (start) begin
         fsm_d  = S_INIT;
         rnd_d  = 4'd0;
         text_d = start_text;
         busy_d = 1'b1;
         if (OUT_CLR != 0) out_d = '0;
      end else begin
         case (fsm_q)
            S_INIT: begin
               state_d = text_q ^ rk;
               rnd_d   = 4'd1;
               fsm_d   = S_RND;
            end
            S_RND: begin
               if (rnd_q == 4'd10) begin
                  out_d  = round_out;
                  done_d = 1'b1;
                  busy_d = 1'b0;
                  rnd_d  = 4'd0;
                  fsm_d  = S_IDLE;
               end else begin
                  state_d = round_out;
                  rnd_d   = rnd_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Core registers; an asynchronous reset abandons any block in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q   <= S_IDLE;
         rnd_q   <= 4'd0;
         state_q <= '0;
         text_q  <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         rnd_q   <= rnd_d;
         state_q <= state_d;
         text_q  <= text_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign text_out = out_q;
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb/tb_aes_enc_iter.sv - Self-checking bench for aes_enc_iter (both OUT_CLR settings)
module tb_aes_enc_iter;
   localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   localparam logic [127:0] SROW [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ld = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] text_in = '0;
   logic busy0, done0, busy1, done1;
   logic [127:0] out0, out1;
`ifdef AES_ENC_LD_QUEUE_EN
   logic ovf0, ovf1;
`endif

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   aes_enc_iter #(.OUT_CLR(0)) dut (
      .clk(clk), .rst(rst), .ld(ld), .key(key), .text_in(text_in),
      .busy(busy0), .done(done0), .text_out(out0)
`ifdef AES_ENC_LD_QUEUE_EN
      , .ovf(ovf0)
`endif
   );

   aes_enc_iter #(.OUT_CLR(1)) dut_clr (
      .clk(clk), .rst(rst), .ld(ld), .key(key), .text_in(text_in),
      .busy(busy1), .done(done1), .text_out(out1)
`ifdef AES_ENC_LD_QUEUE_EN
      , .ovf(ovf1)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference AES-128 built from the FIPS-197 tables and generic field multiply
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbx(input logic [7:0] b);
      logic [127:0] row;
      int idx;
      row = SROW[b[7:4]];
      idx = int'(b[3:0]);
      return row[127-8*idx -: 8];
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
      logic [31:0] w [44];
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] rc, a0, a1, a2, a3;
      logic [31:0] tmp;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbx(tmp[23:16]), sbx(tmp[15:8]), sbx(tmp[7:0]), sbx(tmp[31:24])} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbx(s[i]);
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
               s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
            end
         end
         for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Cycle-level expectation: block in flight with its launch edge, ciphertext and output values
   bit m_act = 0, m_done = 0, busy_prev, done_prev, fin;
   int m_t0 = 0;
   logic [127:0] m_ct = '0, m_out0 = '0, m_out1 = '0;
`ifdef AES_ENC_LD_QUEUE_EN
   bit m_qv = 0, m_ovf = 0;
   logic [127:0] m_qk = '0, m_qp = '0;
`endif

   task automatic launch(input logic [127:0] k, input logic [127:0] p);
      m_act = 1;
      m_t0 = cyc;
      m_ct = aes_model(k, p);
      m_out1 = '0;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_act = 0; m_done = 0; m_out0 = '0; m_out1 = '0;
`ifdef AES_ENC_LD_QUEUE_EN
         m_qv = 0; m_ovf = 0;
`endif
      end else begin
         cyc++;
         busy_prev = m_act;
         done_prev = m_done;
         fin = m_act && (cyc == m_t0 + 11);
         m_done = 0;
`ifdef AES_ENC_LD_QUEUE_EN
         if (fin) begin m_act = 0; m_done = 1; m_out0 = m_ct; m_out1 = m_ct; end
         if (busy_prev) begin
            if (ld) begin
               if (!m_qv) begin m_qv = 1; m_qk = key; m_qp = text_in; end
               else m_ovf = 1;
            end
         end else if (m_qv) begin
            if (ld) begin launch(m_qk, m_qp); m_qk = key; m_qp = text_in; end
            else if (!done_prev) begin launch(m_qk, m_qp); m_qv = 0; end
         end else if (ld) launch(key, text_in);
`else
         if (ld) launch(key, text_in);
         else if (fin) begin m_act = 0; m_done = 1; m_out0 = m_ct; m_out1 = m_ct; end
`endif
      end
   end

   // Per-cycle comparison of both instances against the expectation
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy0, m_act);
         check("done", done0, m_done);
         check("text_out", out0, m_out0);
         check("busy_clr", busy1, m_act);
         check("done_clr", done1, m_done);
         check("text_out_clr", out1, m_out1);
`ifdef AES_ENC_LD_QUEUE_EN
         check("ovf", ovf0, m_ovf);
         check("ovf_clr", ovf1, m_ovf);
`endif
      end
   end

   task automatic drive_ld(input logic [127:0] k, input logic [127:0] p, output int t);
      t = cyc;
      ld = 1'b1;
      key = k;
      text_in = p;
      @(negedge clk);
      ld = 1'b0;
   endtask

   task automatic wait_done(output int t);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done0 && n < 60);
      t = cyc;
      if (!done0) check("done_timeout", 0, 1);
   endtask

   initial begin
      int t1, t2, td, nd;
      check("model_c1", aes_model(C1K, C1P), C1C);
      check("model_appb", aes_model(BK, BP), BC);
      check("model_zero", aes_model('0, '0), ZC);

      repeat (3) @(negedge clk);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_text_out", out0, 0);
      check("rst_text_out_clr", out1, 0);
      rst = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      drive_ld(C1K, C1P, t1);
      wait_done(td);
      check("c1_latency", td - t1, 12);
      check("c1_ct", out0, C1C);
      @(negedge clk);
      check("c1_busy_after", busy0, 0);
      check("c1_done_after", done0, 0);

      drive_ld(BK, BP, t1);
      wait_done(td);
      check("appb_latency", td - t1, 12);
      check("appb_ct", out0, BC);
      drive_ld(C1K, C1P, t1);
      wait_done(td);
      check("b2b_latency", td - t1, 12);
      check("b2b_ct", out0, C1C);
      repeat (2) @(negedge clk);

`ifdef AES_ENC_LD_QUEUE_EN
      drive_ld(BK, BP, t1);
      @(negedge clk);
      @(negedge clk);
      drive_ld(C1K, C1P, t2);
      check("q_ovf_before", ovf0, 0);
      drive_ld('0, '0, t2);
      check("q_ovf_set", ovf0, 1);
      wait_done(td);
      check("q_first_latency", td - t1, 12);
      check("q_first_ct", out0, BC);
      wait_done(td);
      check("q_second_latency", td - t1, 25);
      check("q_second_ct", out0, C1C);
`else
      drive_ld(BK, BP, t1);
      repeat (4) @(negedge clk);
      drive_ld(C1K, C1P, t2);
      wait_done(td);
      check("restart_latency", td - t2, 12);
      check("restart_from_first", td - t1, 17);
      check("restart_ct", out0, C1C);
`endif
      repeat (2) @(negedge clk);

      drive_ld('0, '0, t1);
      check("zero_hold_out", out0, C1C);
      check("zero_clr_out", out1, 0);
      wait_done(td);
      check("zero_latency", td - t1, 12);
      check("zero_ct", out0, ZC);
      check("zero_ct_clr", out1, ZC);
      repeat (2) @(negedge clk);

      drive_ld(C1K, C1P, t1);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", busy0, 0);
      check("arst_done", done0, 0);
      check("arst_text_out", out0, 0);
      check("arst_text_out_clr", out1, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      nd = 0;
      repeat (20) begin
         @(negedge clk);
         if (done0 || done1) nd++;
      end
      check("arst_no_done", nd, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
